muldiv_unit: RTL and testbench

Iterative RV64 M-extension multiply/divide unit in the EX stage. It sits directly downstream of the ID register file and consumes its two read-data outputs as operands. One operation runs at a time: radix-2, one bit per cycle, 64 iterations. A start/busy/done handshake lets the control path stall the pipeline until the result and destination register address are ready for write-back.

---
 rtl/muldiv_unit_pkg.sv | 21 ++
 rtl/muldiv_signfix.sv | 10 +
 rtl/muldiv_unit.sv | 83 ++++++++
 tb/tb_muldiv_unit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared widths, funct3 codes, FSM states and operand-sign helpers
package muldiv_unit_pkg;
  localparam int REG_DATA_WIDTH = 64;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int MD_ITER = 64;
  localparam logic [2:0] MD_MUL = 3'b000;
  localparam logic [2:0] MD_MULH = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU = 3'b011;
  localparam logic [2:0] MD_DIV = 3'b100;
  localparam logic [2:0] MD_DIVU = 3'b101;
  localparam logic [2:0] MD_REM = 3'b110;
  localparam logic [2:0] MD_REMU = 3'b111;
  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_e;
  function automatic logic a_signed(input logic [2:0] f);
    return f == MD_MULH || f == MD_MULHSU || f == MD_DIV || f == MD_REM;
  endfunction
  function automatic logic b_signed(input logic [2:0] f);
    return f == MD_MULH || f == MD_DIV || f == MD_REM;
  endfunction
endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: conditional two's-complement negate
module muldiv_signfix #(
  parameter int W = 64
) (
  input  logic         neg,
  input  logic [W-1:0] value,
  output logic [W-1:0] fixed
);
  assign fixed = neg ? -value : value;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 RV64M multiply/divide with start/busy/done handshake
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [2:0]                funct3,
  input  logic [REG_DATA_WIDTH-1:0] operand_a,
  input  logic [REG_DATA_WIDTH-1:0] operand_b,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
  output logic                      busy,
  output logic                      done,
  output logic [REG_DATA_WIDTH-1:0] result,
  output logic [REG_ADDR_WIDTH-1:0] result_rd_addr
);
  md_state_e state, state_n;
  logic [5:0] cnt;
  logic [127:0] acc, acc_next, fix_in, fix_out;
  logic [63:0] b_q, abs_a, abs_b, sp_res, fin, div_diff;
  logic [2:0] f3_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic neg_q, sa, sb, divz, ovf, special, accept, last, div_ge;
  logic [64:0] mul_sum, div_sh;
  assign sa = a_signed(funct3) & operand_a[63];
  assign sb = b_signed(funct3) & operand_b[63];
  muldiv_signfix #(.W(64)) u_abs_a (.neg(sa), .value(operand_a), .fixed(abs_a));
  muldiv_signfix #(.W(64)) u_abs_b (.neg(sb), .value(operand_b), .fixed(abs_b));
  assign divz = funct3[2] && operand_b == '0;
  assign ovf = funct3[2] && !funct3[0] && operand_a == {1'b1, 63'd0} && operand_b == '1;
  assign special = divz || ovf;
  assign sp_res = divz ? (funct3[1] ? operand_a : '1) : (funct3[1] ? '0 : operand_a);
  assign accept = state == MD_IDLE && start;
  assign last = cnt == 6'(MD_ITER - 1);
  // Multiply: acc = {partial high, remaining multiplier bits}; divide: acc = {remainder, dividend/quotient}
  assign mul_sum = {1'b0, acc[127:64]} + (acc[0] ? {1'b0, b_q} : 65'd0);
  assign div_sh = {acc[127:64], acc[63]};
  assign div_ge = div_sh >= {1'b0, b_q};
  assign div_diff = div_sh[63:0] - b_q;
  assign acc_next = f3_q[2] ? {div_ge ? div_diff : div_sh[63:0], acc[62:0], div_ge} : {mul_sum, acc[63:1]};
  assign fix_in = f3_q[2] ? {64'd0, f3_q[1] ? acc_next[127:64] : acc_next[63:0]} : acc_next;
  muldiv_signfix #(.W(128)) u_fix (.neg(neg_q), .value(fix_in), .fixed(fix_out));
  assign fin = (f3_q == MD_MUL || f3_q[2]) ? fix_out[63:0] : fix_out[127:64];
  always_ff @(posedge clk)
    if (reset) state <= MD_IDLE;
    else state <= state_n;
  always_comb
    state_n = state == MD_IDLE ? (start ? (special ? MD_DONE : MD_RUN) : MD_IDLE) :
              state == MD_RUN  ? (last ? MD_DONE : MD_RUN) : MD_IDLE;
  always_comb begin
    busy = state != MD_IDLE;
    done = state == MD_DONE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      acc <= '0;
      b_q <= '0;
      f3_q <= '0;
      neg_q <= 1'b0;
      rd_q <= '0;
      result <= '0;
      result_rd_addr <= '0;
    end else if (accept) begin
      cnt <= '0;
      acc <= {64'd0, funct3[2] ? abs_a : abs_b};
      b_q <= funct3[2] ? abs_b : abs_a;
      f3_q <= funct3;
      neg_q <= funct3[2] && funct3[1] ? sa : sa ^ sb;
      rd_q <= rd_addr;
      if (special) begin
        result <= sp_res;
        result_rd_addr <= rd_addr;
      end
    end else if (state == MD_RUN) begin
      cnt <= cnt + 6'd1;
      acc <= acc_next;
      if (last) begin
        result <= fin;
        result_rd_addr <= rd_q;
      end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (directed plan plus random ops vs operator model)
module tb_muldiv_unit;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [2:0] funct3 = '0;
  logic [63:0] operand_a = '0, operand_b = '0, result;
  logic [4:0] rd_addr = '0, result_rd_addr;
  logic busy, done, prev_done = 1'b0;
  int cyc = 0, n_checks = 0, n_fail = 0;
  typedef struct {
    logic [63:0] res;
    logic [4:0] rd;
    int start_edge;
    int lat;
  } exp_t;
  exp_t sb[$];
  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .operand_a(operand_a), .operand_b(operand_b), .rd_addr(rd_addr),
    .busy(busy), .done(done), .result(result), .result_rd_addr(result_rd_addr)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at edge %0d", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [63:0] ref_op(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] up, sp, su;
    logic [63:0] q, r;
    up = {64'd0, a} * {64'd0, b};
    sp = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
    su = $signed({{64{a[63]}}, a}) * $signed({64'd0, b});
    q = $signed(a) / $signed(b);
    r = $signed(a) % $signed(b);
    case (f)
      3'd0: return up[63:0];
      3'd1: return sp[127:64];
      3'd2: return su[127:64];
      3'd3: return up[127:64];
      3'd4: return b == 0 ? '1 : (a == MIN && b == '1) ? a : q;
      3'd5: return b == 0 ? '1 : a / b;
      3'd6: return b == 0 ? a : (a == MIN && b == '1) ? 64'd0 : r;
      default: return b == 0 ? a : a % b;
    endcase
  endfunction
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_done) check("done_pulse_width", done, 0);
      if (done) begin
        if (sb.size() == 0) check("spurious_done", done, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("result", result, e.res);
          check("result_rd_addr", result_rd_addr, e.rd);
          check("latency", 64'(cyc - e.start_edge + 1), 64'(e.lat));
        end
      end
    end
    prev_done = done;
  end
  task automatic issue(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, input logic [63:0] exp_res);
    logic spc;
    spc = f[2] && (b == 0 || (!f[0] && a == MIN && b == '1));
    @(negedge clk);
    start = 1'b1; funct3 = f; operand_a = a; operand_b = b; rd_addr = rd;
    sb.push_back('{exp_res, rd, cyc + 1, spc ? 1 : 65});
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask
  task automatic wait_empty();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("timeout_waiting_done", 0, 1);
      sb.delete();
    end
    @(negedge clk);
    check("busy_released", busy, 0);
  endtask
  task automatic run(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                     input logic [4:0] rd, input logic [63:0] exp_res);
    issue(f, a, b, rd, exp_res);
    wait_empty();
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_rd", result_rd_addr, 0);
    reset = 1'b0;
    run(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd17, 64'hFFFF_FFFF_FFFF_FFEB);
    run(3'd3, '1, '1, 5'd1, 64'hFFFF_FFFF_FFFF_FFFE);
    run(3'd1, '1, '1, 5'd2, 64'd0);
    run(3'd2, '1, 64'd2, 5'd3, '1);
    run(3'd4, -64'sd7, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFD);
    run(3'd6, -64'sd7, 64'd2, 5'd5, '1);
    run(3'd5, 64'd100, 64'd7, 5'd6, 64'd14);
    run(3'd7, 64'd100, 64'd7, 5'd7, 64'd2);
    run(3'd5, 64'd42, 64'd0, 5'd8, '1);
    run(3'd7, 64'd42, 64'd0, 5'd9, 64'd42);
    run(3'd4, MIN, '1, 5'd10, MIN);
    run(3'd6, MIN, '1, 5'd11, 64'd0);
    // Second start mid-MUL must be dropped; it is only accepted once busy falls
    issue(3'd0, 64'd11, 64'd13, 5'd12, 64'd143);
    repeat (9) @(negedge clk);
    start = 1'b1; funct3 = 3'd5; operand_a = 64'd1; operand_b = 64'd0; rd_addr = 5'd13;
    @(negedge clk);
    start = 1'b0;
    wait_empty();
    run(3'd5, 64'd1, 64'd0, 5'd13, '1);
    // Abort a DIV mid-flight; no done may follow
    issue(3'd4, -64'sd1000, 64'd7, 5'd14, ref_op(3'd4, -64'sd1000, 64'd7));
    repeat (28) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_rd", result_rd_addr, 0);
    reset = 1'b0;
    repeat (80) @(negedge clk);
    run(3'd0, 64'd3, 64'd5, 5'd15, 64'd15);
    for (int i = 0; i < 24; i++) begin
      logic [2:0] f;
      logic [63:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 6 == 5) b = '0;
      if (i % 4 == 1) b = 64'($urandom_range(1, 1000));
      if (i % 8 == 3) a = MIN;
      run(f, a, b, 5'(i), ref_op(f, a, b));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
